// File: rtl/bcd_fmt_pkg.sv
// -----------------------------------------------------------------------------
// bcd_fmt_pkg
// Shared types and constants for the bcd_formatter block.
//   state_t  : converter FSM states (IDLE / SHIFT / DONE)
//   SIGN_POS : sign nibble shown as blank/zero
//   SIGN_NEG : sign nibble shown as minus
//   MAG_MAX  : largest magnitude the three display digits can show
//   BCD_W    : width of the packed BCD accumulator and output word
// Optional feature macro used by the block: BCD_FMT_SAT_EN
// -----------------------------------------------------------------------------
package bcd_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]  SIGN_POS = 4'h0;
  localparam logic [3:0]  SIGN_NEG = 4'h1;
  localparam int unsigned MAG_MAX  = 999;
  localparam int          BCD_W    = 16;

endpackage : bcd_fmt_pkg

// File: rtl/bcd_formatter_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit correction: a BCD digit of 5 or more gets
// +3 so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i [3:0] : BCD digit before correction
//   digit_o [3:0] : corrected digit
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3

// File: rtl/bcd_formatter.sv
// -----------------------------------------------------------------------------
// bcd_formatter
// Sequential signed-binary (tenths) to packed-BCD converter for the four-digit
// seven-segment driver. Converts iteratively with shift-and-add-3 and presents
// {sign, decade, unit, tenth}, held stable between conversions.
//
// Parameters:
//   IN_W : input width, two's complement, 4..16
// Ports:
//   clk      : clock, rising edge
//   rstn     : synchronous active-low reset
//   in_data  : signed value in tenths
//   in_valid : conversion request (held until in_ready)
//   in_ready : idle, a request is accepted on this edge
//   data     : {sign, decade, unit, tenth}, registered
//   done     : one-cycle pulse when data updates
//   ovf      : magnitude was clamped to 999 (only with BCD_FMT_SAT_EN)
//
// Optional feature macro: BCD_FMT_SAT_EN
//   defined   : magnitudes above 999 clamp to 999 and raise ovf
//   undefined : thousands digit is dropped (magnitude modulo 1000), no ovf port
// -----------------------------------------------------------------------------
module bcd_formatter
  import bcd_fmt_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BCD_W-1:0] data,
  output logic             done
`ifdef BCD_FMT_SAT_EN
  ,
  output logic             ovf
`endif
);

  // One extra bit so that -2^(IN_W-1) has an exact magnitude.
  localparam int MAG_W = IN_W + 1;
  // The BCD accumulator sits directly above the magnitude so a single left
  // shift of the whole vector moves the next binary bit into the BCD digits.
  localparam int ACC_W = BCD_W + MAG_W;
  localparam int CNT_W = 5;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   data_q, data_d;
  logic               done_q, done_d;

  logic [MAG_W-1:0]   in_ext;
  logic [MAG_W-1:0]   mag_raw;
  logic [MAG_W-1:0]   mag_load;
  logic [BCD_W-1:0]   bcd_corr;
  logic [ACC_W-1:0]   acc_corr;

  // ---------------------------------------------------------------------------
  // Magnitude of the incoming sample
  // ---------------------------------------------------------------------------
  assign in_ext  = {in_data[IN_W-1], in_data};
  assign mag_raw = in_data[IN_W-1] ? (-in_ext) : in_ext;

`ifdef BCD_FMT_SAT_EN
  logic clamp;
  logic sat_q, sat_d;
  logic ovf_q, ovf_d;

  assign clamp    = (17'(mag_raw) > 17'(MAG_MAX));
  assign mag_load = clamp ? MAG_W'(MAG_MAX) : mag_raw;
  assign ovf      = ovf_q;
`else
  assign mag_load = mag_raw;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction of the BCD part of the accumulator
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (acc_q[MAG_W + 4*gi +: 4]),
      .digit_o (bcd_corr[4*gi +: 4])
    );
  end

  assign acc_corr = {bcd_corr, acc_q[MAG_W-1:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef BCD_FMT_SAT_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef BCD_FMT_SAT_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef BCD_FMT_SAT_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[IN_W-1];
          acc_d   = {{BCD_W{1'b0}}, mag_load};
          cnt_d   = '0;
`ifdef BCD_FMT_SAT_EN
          sat_d   = clamp;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        acc_d = acc_corr << 1;
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == IN_W marks the MAG_W-th shift.
        if (cnt_q == CNT_W'(IN_W)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Thousands digit (top nibble of the accumulator) is not shown.
        data_d  = {sign_q ? SIGN_NEG : SIGN_POS, acc_q[MAG_W +: 12]};
        done_d  = 1'b1;
`ifdef BCD_FMT_SAT_EN
        ovf_d   = sat_q;
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign data     = data_q;
  assign done     = done_q;

endmodule : bcd_formatter

// File: tb/tb_bcd_formatter.sv
module tb_bcd_formatter;

  localparam int IN_W = 12;

  logic            clk;
  logic            rstn;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     data;
  logic            done;
`ifdef BCD_FMT_SAT_EN
  logic            ovf;
`endif

  int total = 0;
  int bad   = 0;

  bcd_formatter #(.IN_W(IN_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .done     (done)
`ifdef BCD_FMT_SAT_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of |value| from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [IN_W-1:0] v, output logic ovf_e);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    ovf_e = 1'b0;
`ifdef BCD_FMT_SAT_EN
    if (m > 999) begin
      m = 999;
      ovf_e = 1'b1;
    end
`endif
    m = m % 1000;
    return {(s < 0) ? 4'h1 : 4'h0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic do_conv(input logic [IN_W-1:0] v, input string tag);
    logic [15:0] exp_d;
    logic        exp_o;
    int          lat;
    exp_d = model(v, exp_o);
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);                 // acceptance edge has passed
    in_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd14);
    check({tag, "_data"}, 32'(data), 32'(exp_d));
`ifdef BCD_FMT_SAT_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
`endif
    $display("conv %s in=%0d data=%h expected=%h latency=%0d", tag, $signed(v), data, exp_d, lat);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    logic [IN_W-1:0] rv;

    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data",  32'(data),     32'h0);
    check("rst_done",  32'(done),     32'd0);
`ifdef BCD_FMT_SAT_EN
    check("rst_ovf",   32'(ovf),      32'd0);
`endif
    rstn = 1'b1;

    // Directed values from the test plan
    do_conv(12'd123,  "p123");
    do_conv(12'hFD3,  "m45");
    do_conv(12'd0,    "zero");
    do_conv(12'd999,  "p999");
    do_conv(12'd1500, "p1500");
    do_conv(12'h800,  "m2048");
    do_conv(12'd1,    "p1");
    do_conv(12'hFFF,  "m1");
    do_conv(12'h7FF,  "p2047");

    // Random values
    for (int i = 0; i < 20; i++) begin
      rv = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      do_conv(rv, $sformatf("rnd%0d", i));
    end

    // Back-to-back: request held, value changed mid-conversion
    @(negedge clk);
    in_data  = 12'd7;
    in_valid = 1'b1;
    @(negedge clk);                 // 7 accepted at edge k
    in_data  = 12'd8;
    for (int i = 0; i < 14; i++) begin
      check("b2b_ready_low", 32'(in_ready), 32'd0);
      check("b2b_no_done",   32'(done),     32'd0);
      @(negedge clk);
    end
    check("b2b_done1",  32'(done),     32'd1);
    check("b2b_data1",  32'(data),     32'h0007);
    check("b2b_ready1", 32'(in_ready), 32'd1);
    $display("conv b2b_first data=%h", data);
    @(negedge clk);                 // 8 accepted on first IDLE edge
    check("b2b_accept2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i != 0) check("b2b_no_done2", 32'(done), 32'd0);
      if (i != 0) check("b2b_hold1",    32'(data), 32'h0007);
      @(negedge clk);
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_data2", 32'(data), 32'h0008);
    $display("conv b2b_second data=%h", data);

    // Reset at shift 5 of converting 321
    @(negedge clk);
    in_data  = 12'd321;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_done",  32'(done),     32'd0);
    check("abort_data",  32'(data),     32'h0);
    check("abort_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    $display("abort 321 data=%h pulses=%0d", data, pulses);

    // Reset and request together: request dropped
    do_conv(12'd55, "pre_sim");
    @(negedge clk);
    rstn     = 1'b0;
    in_data  = 12'd66;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("simrst_no_pulse", 32'(pulses),   32'd0);
    check("simrst_data",     32'(data),     32'h0);
    check("simrst_ready",    32'(in_ready), 32'd1);
    $display("simrst data=%h pulses=%0d", data, pulses);

    do_conv(12'hFD3, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_formatter

// File: doc/bcd_formatter.md
# bcd_formatter

Sequential signed-binary to packed-BCD converter that feeds the four-digit seven-segment display driver. It accepts a two's-complement reading in units of 0.1 and converts it iteratively (shift-and-add-3). It presents a 16-bit word `{sign, decade, unit, tenth}`, one nibble per digit, where sign nibble 4'h1 shows as minus and 4'h0 as blank/zero. Output is held stable between conversions, so the display driver can sample it asynchronously to its own scan rate.

## Interface
- `IN_W`, default 12: input width, two's complement, legal range 4..16.
- `clk`  in  1: sole clock, rising edge.
- `rstn`  in  1: synchronous, active-low reset.
- `in_data`  in  IN_W: signed value in tenths.
- `in_valid`  in  1: request a conversion of `in_data`.
- `in_ready`  out  1: block is idle and will accept on this edge.
- `data`  out  16: `{sign[15:12], decade[11:8], unit[7:4], tenth[3:0]}`, registered.
- `done`  out  1: one-cycle pulse when `data` updates.
- `ovf`  out  1: exists only with `BCD_FMT_SAT_EN`; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture the sign (MSB of `in_data`) and the magnitude.
  - Magnitude is computed at IN_W+1 bits, so -2^(IN_W-1) is exact.
  - Clear the 16-bit BCD accumulator, clear the iteration counter, go to SHIFT.
- **SHIFT**
  - Each cycle: every BCD nibble ≥5 gets +3, then {bcd, mag} shifts left by 1.
  - Counter increments each cycle.
  - After IN_W+1 shifts, go to DONE.
- **DONE**
  - Register `data` and pulse `done`=1.
  - Low three BCD digits go to decade/unit/tenth.
  - Sign nibble: 4'h1 if the captured sign is negative, else 4'h0.
  - Return to IDLE.
- `in_valid` while not IDLE is ignored; no queueing.
- Upstream must hold the request until it sees `in_ready`.
- `data` changes only on the DONE transition and otherwise holds its last value.
- Digit bits ≥ bit 12 of the accumulator (thousands) are discarded or clamped per Configuration.

## Timing
- Reset values, taking effect on the first rising edge with `rstn`=0:
  - state IDLE, `data`=16'h0000, `done`=0, `ovf`=0, counter 0.
  - `in_ready`=1 from the first cycle after reset.
- Acceptance at edge k:
  - SHIFT runs for edges k+1 .. k+IN_W+1.
  - `data`/`done` update at edge k+IN_W+2; `in_ready` returns high after that same edge.
  - Latency is IN_W+2 cycles (14 for IN_W=12).
- Throughput: one conversion per IN_W+2 cycles, with back-to-back requests honoured on the first IDLE edge.
- Reset asserted mid-conversion: abort immediately, no `done` pulse, `data` forced to 0.
- Simultaneous `rstn`=0 and `in_valid`=1: reset wins and the request is dropped.

## Configuration
- Macro: `BCD_FMT_SAT_EN`.
- **Defined**
  - Magnitude >999 is clamped to 999 before conversion.
  - `ovf` is registered at the DONE transition: 1 if clamped, else 0. It holds until the next DONE or reset.
- **Undefined**
  - No clamp logic and no `ovf` port.
  - Out-of-range values show the magnitude modulo 1000, i.e. the thousands digit is dropped.

## Structure
- Package `bcd_fmt_pkg`:
  - state enum (IDLE/SHIFT/DONE)
  - `SIGN_POS`=4'h0, `SIGN_NEG`=4'h1
  - `MAG_MAX`=999
  - `BCD_W`=16
- Sub-module `bcd_add3`: purely combinational 4-bit "≥5 then +3" digit correction, instantiated four times.

## Test plan
- IN_W=12, `in_data`=123 → at edge k+14: `data`=16'h0123, `done` high one cycle, `ovf`=0.
- `in_data`=-45 (12'hFD3) → `data`=16'h1045; `in_data`=0 → 16'h0000; `in_data`=999 → 16'h0999.
- `in_data`=1500:
  - SAT_EN → 16'h0999, `ovf`=1.
  - without it → 16'h0500.
- `in_data`=-2048:
  - SAT_EN → 16'h1999, `ovf`=1.
  - without it → 16'h1048.
- `in_valid` held continuously with values 7 then 8:
  - `in_ready` low for 14 cycles.
  - `data` goes 16'h0007 then 16'h0008, 14 cycles apart.
  - A mid-conversion value change is ignored.
- `rstn` low for one cycle at shift 5 of converting 321 → no `done` pulse, `data`=16'h0000, `in_ready`=1 the next cycle.
